// File: rtl/issuequeue_int_pkg.sv
// Shared processor constants and the integer issue-queue entry record.
// The wakeup helper is shared by the entry storage and by the dispatch path.
package issuequeue_int_pkg;

  localparam int TAG_W    = 6;
  localparam int DATA_W   = 32;
  localparam int OPC_W    = 4;
  localparam int IQ_DEPTH = 4;
  localparam int CNT_W    = $clog2(IQ_DEPTH + 1);
  localparam int IDX_W    = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  rdtag;
    logic [TAG_W-1:0]  rstag;
    logic [DATA_W-1:0] rsdata;
    logic              rsvalid;
    logic [TAG_W-1:0]  rttag;
    logic [DATA_W-1:0] rtdata;
    logic              rtvalid;
  } iq_entry_t;

  // Capture a CDB broadcast into any still-waiting source of a valid entry.
  function automatic iq_entry_t cdb_wakeup(
    input iq_entry_t         e,
    input logic              bus_valid,
    input logic [TAG_W-1:0]  bus_tag,
    input logic [DATA_W-1:0] bus_data
  );
    iq_entry_t r;
    r = e;
    if (bus_valid && e.valid && !e.rsvalid && (e.rstag == bus_tag)) begin
      r.rsdata  = bus_data;
      r.rsvalid = 1'b1;
    end
    if (bus_valid && e.valid && !e.rtvalid && (e.rttag == bus_tag)) begin
      r.rtdata  = bus_data;
      r.rtvalid = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/issuequeue_int_iq_entry.sv
// One issue-queue slot: holds an instruction, snoops the CDB for its sources,
// and accepts either a new dispatch or the entry shifting down from above.
module iq_entry
  import issuequeue_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load_en,
  input  iq_entry_t         load_entry,
  input  logic              shift_en,
  input  iq_entry_t         shift_entry,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tagout,
  input  logic [DATA_W-1:0] cdb_out,
  output iq_entry_t         entry,
  output logic              ready
);

  iq_entry_t next_entry;

  // Pick the source of next contents (dispatch wins over shift-in), then wake it up.
  always_comb begin
    next_entry = entry;
    if (load_en) begin
      next_entry = load_entry;
    end else if (shift_en) begin
      next_entry = shift_entry;
    end
    next_entry = cdb_wakeup(next_entry, cdb_valid, cdb_tagout, cdb_out);
  end

  // Reset and flush both empty the slot; otherwise take the selected next contents.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      entry <= '0;
    end else begin
      entry <= next_entry;
    end
  end

  // Readiness looks only at stored state, so a wakeup shows up one cycle later.
  always_comb begin
    ready = entry.valid & entry.rsvalid & entry.rtvalid;
  end

endmodule

// File: rtl/issuequeue_int.sv
// Integer issue queue: compacted, oldest-first, four entries.
// Selection, occupancy count and compaction control live here; storage and
// wakeup live in the iq_entry slots.
module issuequeue_int
  import issuequeue_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tagout,
  input  logic [DATA_W-1:0] cdb_out,
  input  logic              flush,
  input  logic              issue_int,
  output logic              issuequeue_full,
  output logic              ready_int,
  output logic [OPC_W-1:0]  opcode,
  output logic [TAG_W-1:0]  rdtag,
  output logic [DATA_W-1:0] rsdata,
  output logic [DATA_W-1:0] rtdata
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_slot;
  logic [IDX_W-1:0] sel_idx;
  logic             issued;
  logic             accepted;

  iq_entry_t entries     [IQ_DEPTH];
  iq_entry_t shift_src   [IQ_DEPTH];
  iq_entry_t sel_entry;
  iq_entry_t new_entry;

  logic [IQ_DEPTH-1:0] ready_vec;
  logic [IQ_DEPTH-1:0] load_vec;
  logic [IQ_DEPTH-1:0] shift_vec;

  // Full is purely the registered occupancy; a same-cycle issue does not free a slot early.
  always_comb begin
    issuequeue_full = (count == CNT_W'(IQ_DEPTH));
  end

  // Lowest-index ready entry wins, which is also the oldest ready instruction.
  always_comb begin
    sel_idx   = '0;
    ready_int = 1'b0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_idx   = IDX_W'(i);
        ready_int = 1'b1;
      end
    end
  end

  // Payload outputs are zero when nothing is ready so downstream sees a clean bubble.
  always_comb begin
    sel_entry = ready_int ? entries[sel_idx] : '0;
    opcode    = sel_entry.opcode;
    rdtag     = sel_entry.rdtag;
    rsdata    = sel_entry.rsdata;
    rtdata    = sel_entry.rtdata;
  end

  // Handshake qualification: a grant without a ready entry and a dispatch into a full
  // queue or during flush are both dropped without effect.
  always_comb begin
    issued    = issue_int & ready_int;
    accepted  = dispatch_en & ~issuequeue_full & ~flush;
    load_slot = count - CNT_W'(issued);
  end

  // Build the incoming entry; a source broadcast on the CDB this very cycle is caught
  // by the wakeup inside the slot, since the slot applies wakeup to whatever it loads.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.opcode  = dispatch_opcode;
    new_entry.rdtag   = dispatch_rdtag;
    new_entry.rstag   = dispatch_rstag;
    new_entry.rsdata  = dispatch_rsdata;
    new_entry.rsvalid = dispatch_rsvalid;
    new_entry.rttag   = dispatch_rttag;
    new_entry.rtdata  = dispatch_rtdata;
    new_entry.rtvalid = dispatch_rtvalid;
  end

  // Compaction: on issue, the selected slot and every slot above it take their upper
  // neighbour; the top slot takes an empty entry. Dispatch lands just past the survivors.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      shift_src[i] = '0;
      load_vec[i]  = accepted && (load_slot == CNT_W'(i));
      shift_vec[i] = issued && (i >= int'(sel_idx));
    end
    for (int i = 0; i < IQ_DEPTH - 1; i++) begin
      shift_src[i] = entries[i+1];
    end
  end

  // Occupancy tracks accepted dispatches minus real issues; reset and flush empty it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(accepted) - CNT_W'(issued);
    end
  end

  for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_entry
    iq_entry u_entry (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .load_en     (load_vec[g]),
      .load_entry  (new_entry),
      .shift_en    (shift_vec[g]),
      .shift_entry (shift_src[g]),
      .cdb_valid   (cdb_valid),
      .cdb_tagout  (cdb_tagout),
      .cdb_out     (cdb_out),
      .entry       (entries[g]),
      .ready       (ready_vec[g])
    );
  end

endmodule

// File: tb/tb_issuequeue_int.sv
// Directed bench for the integer issue queue. The stimulus thread pushes the
// expected payload of each grant into a scoreboard queue; a monitor pops and
// compares whenever the DUT actually issues.
module tb_issuequeue_int;

  logic        clk;
  logic        reset;
  logic        dispatch_en;
  logic [3:0]  dispatch_opcode;
  logic [5:0]  dispatch_rstag;
  logic [5:0]  dispatch_rttag;
  logic [31:0] dispatch_rsdata;
  logic [31:0] dispatch_rtdata;
  logic        dispatch_rsvalid;
  logic        dispatch_rtvalid;
  logic [5:0]  dispatch_rdtag;
  logic        cdb_valid;
  logic [5:0]  cdb_tagout;
  logic [31:0] cdb_out;
  logic        flush;
  logic        issue_int;
  logic        issuequeue_full;
  logic        ready_int;
  logic [3:0]  opcode;
  logic [5:0]  rdtag;
  logic [31:0] rsdata;
  logic [31:0] rtdata;

  typedef struct {
    logic [3:0]  opc;
    logic [5:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   check_count = 0;
  int   pass_count  = 0;

  issuequeue_int dut (
    .clk              (clk),
    .reset            (reset),
    .dispatch_en      (dispatch_en),
    .dispatch_opcode  (dispatch_opcode),
    .dispatch_rstag   (dispatch_rstag),
    .dispatch_rttag   (dispatch_rttag),
    .dispatch_rsdata  (dispatch_rsdata),
    .dispatch_rtdata  (dispatch_rtdata),
    .dispatch_rsvalid (dispatch_rsvalid),
    .dispatch_rtvalid (dispatch_rtvalid),
    .dispatch_rdtag   (dispatch_rdtag),
    .cdb_valid        (cdb_valid),
    .cdb_tagout       (cdb_tagout),
    .cdb_out          (cdb_out),
    .flush            (flush),
    .issue_int        (issue_int),
    .issuequeue_full  (issuequeue_full),
    .ready_int        (ready_int),
    .opcode           (opcode),
    .rdtag            (rdtag),
    .rsdata           (rsdata),
    .rtdata           (rtdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance one clock: inputs set before this call are sampled at the edge;
  // returns 1 time unit after the edge with registered state settled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_en = 1'b0;
    issue_int   = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic setDispatch(input logic [3:0] opc, input logic [5:0] rst, input logic [31:0] rsd,
                             input logic rsv, input logic [5:0] rtt, input logic [31:0] rtd,
                             input logic rtv, input logic [5:0] rd);
    dispatch_en      = 1'b1;
    dispatch_opcode  = opc;
    dispatch_rstag   = rst;
    dispatch_rsdata  = rsd;
    dispatch_rsvalid = rsv;
    dispatch_rttag   = rtt;
    dispatch_rtdata  = rtd;
    dispatch_rtvalid = rtv;
    dispatch_rdtag   = rd;
  endtask

  task automatic setCdb(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid  = 1'b1;
    cdb_tagout = tag;
    cdb_out    = data;
  endtask

  task automatic expectIssue(input logic [3:0] opc, input logic [5:0] rd, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    e.opc = opc;
    e.rd  = rd;
    e.rs  = rs;
    e.rt  = rt;
    expq.push_back(e);
    issue_int = 1'b1;
  endtask

  // Monitor: every real grant must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && !flush && issue_int && ready_int) begin
      if (expq.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_issue: got op=%0h rd=%0h rs=%0h rt=%0h, expected no issue",
                 opcode, rdtag, rsdata, rtdata);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("issue_payload", {6'd0, opcode, rdtag, rsdata, rtdata},
                    {6'd0, mon_e.opc, mon_e.rd, mon_e.rs, mon_e.rt});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    setDispatch(0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_en = 1'b0;
    cdb_tagout  = '0;
    cdb_out     = '0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_full",  issuequeue_full, 0);
    checkOutput("rst_ready", ready_int, 0);
    checkOutput("rst_payload", {opcode, rdtag, rsdata, rtdata}, 0);

    $display("[TB] both sources valid, issue next cycle");
    setDispatch(1, 0, 5, 1, 0, 7, 1, 3);
    applyStimulus();
    idle();
    checkOutput("t1_ready", ready_int, 1);
    expectIssue(1, 3, 5, 7);
    applyStimulus();
    idle();
    checkOutput("t1_ready_after", ready_int, 0);
    checkOutput("t1_full_after", issuequeue_full, 0);
    checkOutput("t1_payload_zero", {opcode, rdtag, rsdata, rtdata}, 0);

    $display("[TB] CDB wakeup two cycles after dispatch");
    setDispatch(2, 12, 0, 0, 0, 1, 1, 4);
    applyStimulus();
    idle();
    checkOutput("t2_wait_ready", ready_int, 0);
    applyStimulus();
    setCdb(12, 32'hDEAD);
    checkOutput("t2_cdb_cycle_ready", ready_int, 0);
    applyStimulus();
    idle();
    checkOutput("t2_woken_ready", ready_int, 1);
    checkOutput("t2_woken_rsdata", rsdata, 32'hDEAD);
    expectIssue(2, 4, 32'hDEAD, 1);
    applyStimulus();
    idle();

    $display("[TB] CDB hit at dispatch");
    setDispatch(3, 0, 32'h11, 1, 9, 0, 0, 5);
    setCdb(9, 32'h42);
    applyStimulus();
    idle();
    checkOutput("t3_ready", ready_int, 1);
    checkOutput("t3_rtdata", rtdata, 32'h42);
    expectIssue(3, 5, 32'h11, 32'h42);
    applyStimulus();
    idle();

    $display("[TB] fill, middle issue, compaction");
    setDispatch(8, 20, 0, 0, 0, 32'h0A, 1, 9);          applyStimulus();
    setDispatch(4, 0, 32'h100, 1, 0, 32'h101, 1, 10);   applyStimulus();
    setDispatch(5, 21, 0, 0, 0, 32'h0B, 1, 11);         applyStimulus();
    setDispatch(6, 22, 0, 0, 0, 32'h0C, 1, 12);         applyStimulus();
    checkOutput("t4_full", issuequeue_full, 1);
    checkOutput("t4_sel_rdtag", rdtag, 10);
    setDispatch(15, 0, 32'hBAD0, 1, 0, 32'hBAD1, 1, 63);
    applyStimulus();
    checkOutput("t4_full_after_drop", issuequeue_full, 1);
    setDispatch(14, 0, 32'hBAD2, 1, 0, 32'hBAD3, 1, 62);
    expectIssue(4, 10, 32'h100, 32'h101);
    applyStimulus();
    idle();
    checkOutput("t4_full_drops", issuequeue_full, 0);
    checkOutput("t4_none_ready", ready_int, 0);
    setDispatch(7, 0, 32'h700, 1, 0, 32'h701, 1, 13);
    applyStimulus();
    idle();
    checkOutput("t4_refull", issuequeue_full, 1);
    checkOutput("t4_slot3_rdtag", rdtag, 13);
    setCdb(21, 32'h2121);
    applyStimulus();
    idle();
    checkOutput("t4_order_rdtag", rdtag, 11);
    expectIssue(5, 11, 32'h2121, 32'h0B);
    setCdb(22, 32'h2222);
    applyStimulus();
    idle();
    checkOutput("t4_full_after_issue", issuequeue_full, 0);
    expectIssue(6, 12, 32'h2222, 32'h0C);
    applyStimulus();
    idle();
    expectIssue(7, 13, 32'h700, 32'h701);
    applyStimulus();
    idle();
    checkOutput("t4_oldest_waiting", ready_int, 0);
    setCdb(20, 32'h2020);
    applyStimulus();
    idle();
    checkOutput("t4_oldest_woken", ready_int, 1);
    expectIssue(8, 9, 32'h2020, 32'h0A);
    applyStimulus();
    idle();
    checkOutput("t4_empty_ready", ready_int, 0);
    checkOutput("t4_empty_full", issuequeue_full, 0);

    $display("[TB] flush with concurrent dispatch");
    for (int i = 1; i <= 3; i++) begin
      setDispatch(4'(i), 0, 32'(i), 1, 0, 32'(i + 16), 1, 6'(i));
      applyStimulus();
    end
    idle();
    checkOutput("t5_prefl_ready", ready_int, 1);
    flush = 1'b1;
    setDispatch(9, 0, 32'h99, 1, 0, 32'h98, 1, 40);
    applyStimulus();
    idle();
    checkOutput("t5_flush_ready", ready_int, 0);
    checkOutput("t5_flush_full", issuequeue_full, 0);
    checkOutput("t5_flush_payload", {opcode, rdtag, rsdata, rtdata}, 0);

    $display("[TB] grant with nothing ready is ignored");
    setDispatch(10, 0, 32'hA, 1, 0, 32'hB, 1, 20);
    issue_int = 1'b1;
    applyStimulus();
    idle();
    checkOutput("t6_ready", ready_int, 1);
    expectIssue(10, 20, 32'hA, 32'hB);
    applyStimulus();
    idle();
    checkOutput("t6_empty", ready_int, 0);

    $display("[TB] reset overrides flush, dispatch and issue");
    for (int i = 1; i <= 3; i++) begin
      setDispatch(4'(i), 0, 32'(i), 1, 0, 32'(i), 1, 6'(i + 30));
      applyStimulus();
    end
    reset     = 1'b1;
    flush     = 1'b1;
    issue_int = 1'b1;
    setDispatch(11, 0, 1, 1, 0, 1, 1, 50);
    applyStimulus();
    reset = 1'b0;
    idle();
    checkOutput("t7_reset_ready", ready_int, 0);
    checkOutput("t7_reset_full", issuequeue_full, 0);
    checkOutput("t7_reset_payload", {opcode, rdtag, rsdata, rtdata}, 0);

    applyStimulus();
    applyStimulus();
    checkOutput("scoreboard_drained", 80'(expq.size()), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
